// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with RV32M/RV64M multiply and an iterative restoring divider.
module alu_pipe #(
  parameter int XLEN = 32,
  parameter int SHW = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [5:0]      aluop_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            illegal_o,
  output logic            busy_o
);
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_fast, div_res, mag1, mag2, rem_n;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN:0] shl, diff;
  logic [SHW-1:0] cnt_q, shamt;
  logic is_rem_q, neg_quo_q, neg_rem_q;
  logic accept, is_div, div_sgn, div_zero, div_ovf, op1_neg, op2_neg;
  logic start_div, load_fast, done_load, illegal;
  assign ready_o = rst_ni && !flush_i && state == IDLE && (!valid_o || ready_i);
  assign accept = valid_i && ready_o;
  assign is_div = aluop_i >= 6'd14 && aluop_i <= 6'd17;
  assign div_sgn = aluop_i == 6'd14 || aluop_i == 6'd16;
  assign div_zero = op2_i == '0;
  assign div_ovf = div_sgn && op1_i == {1'b1, {(XLEN-1){1'b0}}} && &op2_i;
  assign start_div = accept && is_div && !div_zero && !div_ovf;
  assign load_fast = accept && !start_div;
  // a finished quotient waits in DIV_DONE if the output register is still occupied
  assign done_load = state == DIV_DONE && (!valid_o || ready_i);
  assign busy_o = state != IDLE;
  assign illegal = aluop_i > 6'd17;
  assign shamt = op2_i[SHW-1:0];
  assign op1_neg = div_sgn && op1_i[XLEN-1];
  assign op2_neg = div_sgn && op2_i[XLEN-1];
  assign mag1 = op1_neg ? -op1_i : op1_i;
  assign mag2 = op2_neg ? -op2_i : op2_i;
  assign mul_a = (aluop_i == 6'd11 || aluop_i == 6'd12) ? {{XLEN{op1_i[XLEN-1]}}, op1_i} : {{XLEN{1'b0}}, op1_i};
  assign mul_b = aluop_i == 6'd11 ? {{XLEN{op2_i[XLEN-1]}}, op2_i} : {{XLEN{1'b0}}, op2_i};
  assign prod = mul_a * mul_b;
  always_comb begin
    res_fast = '0;
    case (aluop_i)
      6'd0:  res_fast = op1_i + op2_i;
      6'd1:  res_fast = op1_i << shamt;
      6'd2:  res_fast = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      6'd3:  res_fast = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      6'd4:  res_fast = op1_i ^ op2_i;
      6'd5:  res_fast = op1_i >> shamt;
      6'd6:  res_fast = op1_i | op2_i;
      6'd7:  res_fast = op1_i & op2_i;
      6'd8:  res_fast = $signed(op1_i) >>> shamt;
      6'd9:  res_fast = op1_i - op2_i;
      6'd10: res_fast = prod[XLEN-1:0];
      6'd11, 6'd12, 6'd13: res_fast = prod[2*XLEN-1:XLEN];
      6'd14, 6'd15: res_fast = div_zero ? '1 : op1_i;
      6'd16, 6'd17: res_fast = div_zero ? op1_i : '0;
      default: res_fast = '0;
    endcase
  end
  assign shl = {rem_q, quo_q[XLEN-1]};
  assign diff = shl - {1'b0, dvs_q};
  assign rem_n = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
  assign div_res = is_rem_q ? (neg_rem_q ? -rem_q : rem_q) : (neg_quo_q ? -quo_q : quo_q);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start_div) ? DIV_RUN :
              (state == DIV_RUN && cnt_q == '0) ? DIV_DONE :
              (state == DIV_DONE && done_load) ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      is_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_o <= 1'b0;
      alu_result_o <= '0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt_q <= '0;
      valid_o <= 1'b0;
    end else begin
      state <= state_n;
      if (start_div) begin
        rem_q <= '0;
        quo_q <= mag1;
        dvs_q <= mag2;
        cnt_q <= SHW'(XLEN-1);
        is_rem_q <= aluop_i >= 6'd16;
        neg_quo_q <= op1_neg ^ op2_neg;
        neg_rem_q <= op1_neg;
      end else if (state == DIV_RUN) begin
        rem_q <= rem_n;
        quo_q <= {quo_q[XLEN-2:0], !diff[XLEN]};
        cnt_q <= cnt_q - SHW'(1);
      end
      if (load_fast) begin
        valid_o <= 1'b1;
        alu_result_o <= res_fast;
        illegal_o <= illegal;
      end else if (done_load) begin
        valid_o <= 1'b1;
        alu_result_o <= div_res;
        illegal_o <= 1'b0;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (XLEN = 32).
module tb_alu_pipe;
  logic clk = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [5:0] aluop_i = '0;
  logic [31:0] op1_i = '0, op2_i = '0, alu_result_o;
  logic ready_o, valid_o, illegal_o, busy_o;
  int total = 0, bad = 0, cyc = 0;
  logic [32:0] exp_q [$];
  typedef struct packed {logic [5:0] op; logic [31:0] a, b, r; logic ill;} vec_t;
  vec_t tbl [0:15] = '{
    '{6'd0,  32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0},
    '{6'd9,  32'h00000000, 32'h00000001, 32'hffffffff, 1'b0},
    '{6'd8,  32'h80000000, 32'h00000024, 32'hf8000000, 1'b0},
    '{6'd2,  32'hffffffff, 32'h00000001, 32'h00000001, 1'b0},
    '{6'd3,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b0},
    '{6'd1,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0},
    '{6'd5,  32'h80000000, 32'h0000001f, 32'h00000001, 1'b0},
    '{6'd4,  32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0},
    '{6'd6,  32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0},
    '{6'd7,  32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0},
    '{6'd10, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0},
    '{6'd11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
    '{6'd13, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b0},
    '{6'd12, 32'hffffffff, 32'h00000002, 32'hffffffff, 1'b0},
    '{6'd20, 32'h12345678, 32'h87654321, 32'h00000000, 1'b1},
    '{6'd63, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1}
  };
  logic [5:0] rops [0:8] = '{6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd15, 6'd17};
  alu_pipe dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .aluop_i(aluop_i), .op1_i(op1_i), .op2_i(op2_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_result_o(alu_result_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) check("spurious_valid", 64'(valid_o), 64'd0);
      else check("result", 64'({illegal_o, alu_result_o}), 64'(exp_q.pop_front()));
    end
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a << b[4:0];
      6'd4: return a ^ b;
      6'd5: return a >> b[4:0];
      6'd6: return a | b;
      6'd7: return a & b;
      6'd9: return a - b;
      6'd15: return b == 0 ? 32'hffffffff : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic ill, input bit push, output int w);
    valid_i = 1'b1;
    aluop_i = op;
    op1_i = a;
    op2_i = b;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) check("accept_timeout", 64'(w), 64'd0);
    @(posedge clk);
    if (push && w < 200) exp_q.push_back({ill, r});
    #1 valid_i = 1'b0;
  endtask
  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic ill, output int lat, output bit busy_hi, output bit gap_bad);
    int w;
    send(op, a, b, r, ill, 1'b1, w);
    lat = 1;
    busy_hi = 1'b0;
    gap_bad = 1'b0;
    @(negedge clk);
    while (!valid_o && lat < 200) begin
      busy_hi |= busy_o;
      if (!busy_o || ready_o) gap_bad = 1'b1;
      lat++;
      @(negedge clk);
    end
    busy_hi |= busy_o;
    step();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w, lat, c0;
    bit bh, bg;
    logic [5:0] op;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", 64'(alu_result_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);
    step();
    run(6'd0, 32'h7fffffff, 32'h1, 32'h80000000, 1'b0, lat, bh, bg);
    check("add_latency", 64'(lat), 64'd1);
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].ill, 1'b1, w);
    check("b2b_cycles", 64'(cyc - c0), 64'd16);
    repeat (2) step();
    run(6'd14, 32'hfffffff9, 32'h2, 32'hfffffffd, 1'b0, lat, bh, bg);
    check("div_latency", 64'(lat), 64'd34);
    check("div_busy_ready", 64'(bg), 64'd0);
    run(6'd16, 32'hfffffff9, 32'h2, 32'hffffffff, 1'b0, lat, bh, bg);
    check("rem_latency", 64'(lat), 64'd34);
    run(6'd15, 32'h5, 32'h0, 32'hffffffff, 1'b0, lat, bh, bg);
    check("divu0_latency", 64'(lat), 64'd1);
    check("divu0_busy", 64'(bh), 64'd0);
    run(6'd16, 32'h5, 32'h0, 32'h5, 1'b0, lat, bh, bg);
    check("rem0_latency", 64'(lat), 64'd1);
    check("rem0_busy", 64'(bh), 64'd0);
    run(6'd14, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b0, lat, bh, bg);
    check("divovf_latency", 64'(lat), 64'd1);
    check("divovf_busy", 64'(bh), 64'd0);
    run(6'd16, 32'h80000000, 32'hffffffff, 32'h0, 1'b0, lat, bh, bg);
    check("removf_busy", 64'(bh), 64'd0);
    for (int i = 0; i < 12; i++) begin
      op = rops[$urandom_range(0, 8)];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run(op, a, b, model(op, a, b), 1'b0, lat, bh, bg);
    end
    ready_i = 1'b0;
    send(6'd0, 32'd7, 32'd8, 32'd15, 1'b0, 1'b1, w);
    @(negedge clk);
    check("stall_valid", 64'(valid_o), 64'd1);
    valid_i = 1'b1;
    aluop_i = 6'd0;
    op1_i = 32'd2;
    op2_i = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({valid_o, ready_o, alu_result_o}), 64'({1'b1, 1'b0, 32'd15}));
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    send(6'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, w);
    check("release_accept", 64'(w), 64'd0);
    step();
    send(6'd14, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, w);
    repeat (9) step();
    flush_i = 1'b1;
    valid_i = 1'b1;
    aluop_i = 6'd0;
    op1_i = 32'd1;
    op2_i = 32'd1;
    @(negedge clk);
    check("flush_ready", 64'(ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_state", 64'({valid_o, busy_o}), 64'd0);
    step();
    run(6'd0, 32'd2, 32'd3, 32'd5, 1'b0, lat, bh, bg);
    check("post_flush_latency", 64'(lat), 64'd1);
    repeat (40) step();
    send(6'd17, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, w);
    repeat (9) step();
    rst_ni = 1'b0;
    step();
    @(negedge clk);
    check("midrst_outputs", 64'({valid_o, illegal_o, busy_o, alu_result_o}), 64'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'd1);
    step();
    run(6'd0, 32'd2, 32'd3, 32'd5, 1'b0, lat, bh, bg);
    check("post_rst_latency", 64'(lat), 64'd1);
    repeat (40) step();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the single-cycle execute-stage ALU of the 5-stage pipeline. It adds RV32M multiply/divide, XLEN-generic operands, and RISC-V-correct shift masking. A valid/ready handshake on input and output lets the pipeline stall while an iterative divide is in flight. It sits in EX, fed from the ID/EX register; its output feeds EX/MEM.

## Interface
- XLEN, 32, operand/result width; must be 32 or 64
- SHW, $clog2(XLEN), shift-amount width; derived, do not override
- clk_i  in  1  clock; all state changes on the rising edge
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  pipeline flush; kills the in-flight op
- valid_i  in  1  upstream op valid
- ready_o  out  1  block can accept an op this cycle
- aluop_i  in  6  operation code
- op1_i  in  XLEN  operand 1 (rs1 / dividend / multiplicand)
- op2_i  in  XLEN  operand 2 (rs2 / imm / divisor / multiplier)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- alu_result_o  out  XLEN  result
- illegal_o  out  1  qualifies valid_o; opcode not in the 0–17 table
- busy_o  out  1  divider running

## Operation
- Opcode map:
  - 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SRA, 9 SUB
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18–63 illegal
- Shifts use only op2_i[SHW-1:0]; upper bits are ignored.
- SLT/SLTU return zero-extended 0/1.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively. Multiply is single-cycle combinational into the output register.
- Divide is a restoring shift-subtract, one quotient bit per cycle, on magnitudes. Signs are fixed up at the end: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Divide special cases complete on the fast path and never enter DIV_RUN:
  - divisor 0: DIV/DIVU → all ones; REM/REMU → op1_i
  - signed overflow (op1 = −2^(XLEN−1), op2 = −1): DIV → op1_i; REM → 0
- Illegal opcode: alu_result_o = 0, illegal_o = 1, base-op latency. X is never driven.
- FSM states:
  - IDLE → DIV_RUN on an accepted non-special divide op
  - DIV_RUN: counter runs XLEN−1 down to 0; → DIV_DONE when the counter is 0
  - DIV_DONE: loads the output register → IDLE
- ready_o = (state == IDLE) && (!valid_o || ready_i).
- An op is accepted on a cycle where valid_i && ready_o. Operands and opcode are latched at acceptance.
- Output register: loaded with valid_o = 1; holds value and valid_o until the cycle valid_o && ready_i. When consumed and reloaded in the same cycle, the new result wins.
- busy_o = (state == DIV_RUN || state == DIV_DONE).
- flush_i (priority over everything except reset):
  - next state IDLE, valid_o = 0, divider counter cleared
  - an op presented alongside flush_i is not accepted; ready_o is forced low that cycle

## Timing
- Reset values: valid_o 0, alu_result_o 0, illegal_o 0, busy_o 0, state IDLE. ready_o goes to 1 in the first cycle after reset deasserts.
- Base ops, multiply, illegal and divide fast path: accepted in cycle N → valid_o in cycle N+1.
- Divide: accepted in cycle N → DIV_RUN for cycles N+1 … N+XLEN → DIV_DONE at N+XLEN+1 → valid_o at N+XLEN+2 (34 cycles for XLEN = 32).
- Back-to-back base ops with ready_i = 1 sustain one result per cycle.
- Reset or flush asserted mid-divide: the divide is abandoned, with no valid_o for it. A new op may be accepted in the cycle after flush_i or reset deasserts.
- Stall with ready_i = 0: alu_result_o and valid_o are stable. No new op is accepted.

## Test plan
- Base ops:
  - ADD 0x7FFFFFFF + 1 → 0x80000000 next cycle
  - SUB 0 − 1 → 0xFFFFFFFF
  - SRA 0x80000000 by op2 = 0x24 (masked shift 4) → 0xF8000000
  - SLT −1 < 1 → 1; SLTU on the same operands → 0
- Multiply:
  - MULH 0x80000000 × 0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU −1 × 2 → 0xFFFFFFFF
- Divide:
  - DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF
  - valid_o exactly 34 cycles after acceptance; ready_o low and busy_o high throughout
- Divide specials:
  - DIVU 5 / 0 → 0xFFFFFFFF
  - REM 5 / 0 → 5
  - DIV 0x80000000 / −1 → 0x80000000
  - each completes in 1 cycle with busy_o never high
- Handshake:
  - hold ready_i = 0 for 3 cycles after valid_o → result stable, ready_o low, next op accepted on the release cycle
  - aluop 20 → result 0, illegal_o = 1
- Flush and reset:
  - flush_i in cycle 10 of a divide → valid_o never asserts for that op; a following ADD 2 + 3 → 5 one cycle after acceptance
  - same sequence with rst_ni low instead of flush_i → all outputs return to their reset values
